// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider sequencer.
// Contents: FSM state encoding, result/start flag constants, the iteration
// count, and a magnitude helper used by the signed-division front end.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam int         DIV_ITERATIONS = 32;
  localparam logic [4:0] DIV_LAST_CNT   = 5'(DIV_ITERATIONS - 1);

  // Two's-complement magnitude when en is set and v is negative.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   i_partial [64:0] : {rem[32:0], quo[31:0]} before the step
//   i_divisor [31:0] : divisor magnitude
//   o_partial [64:0] : {rem[32:0], quo[31:0]} after the step
// The pair is shifted left one bit, then the divisor is trial-subtracted
// from the remainder half; a non-negative difference is kept and the new
// quotient bit is 1, otherwise the shifted value is kept and the bit is 0.
module div_step (
  input  logic [64:0] i_partial,
  input  logic [31:0] i_divisor,
  output logic [64:0] o_partial
);

  logic [64:0] w_shift;
  logic [33:0] w_diff;

  assign w_shift = {i_partial[63:0], 1'b0};
  // One extra bit so the borrow shows up as the sign of the difference.
  assign w_diff  = {1'b0, w_shift[64:32]} - {2'b00, i_divisor};

  assign o_partial = w_diff[33] ? w_shift
                                : {w_diff[32:0], w_shift[31:1], 1'b1};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle divider sequencer for the EX stage (DIV/DIVU), restoring
// division with one quotient bit per clock.
// Optional feature macro: DIV_SIGNED_EN -- when defined, signed_div_i selects
// signed division; when undefined every division is unsigned.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   signed_div_i   : 1 = DIV (signed), 0 = DIVU
//   opdata1_i      : dividend
//   opdata2_i      : divisor
//   start_i        : request, held by EX until the result is consumed
//   annul_i        : abort an in-flight division
//   result_o       : {remainder, quotient} in HI/LO layout
//   ready_o        : result_o valid
//   busy_o         : division running, stall EX
//   dbg_state_o    : current FSM state (debug visibility)
// Handshake: a request is accepted on an edge where the FSM is FREE with
// start_i=1 and annul_i=0. ready_o then stays high with a stable result_o
// for as long as start_i stays high; dropping start_i releases the unit.
module div_seq
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic [1:0]  dbg_state_o
);

  div_state_e  r_state, w_state;
  logic [4:0]  r_cnt, w_cnt;
  logic [64:0] r_part, w_part;
  logic [31:0] r_divisor, w_divisor;
  logic [63:0] r_result, w_result;
  logic        r_ready, w_ready;
  logic        r_busy, w_busy;

  logic [64:0] w_step;
  logic [31:0] w_op1_mag, w_op2_mag;
  logic [31:0] w_quo, w_rem;

  div_step u_step (
    .i_partial (r_part),
    .i_divisor (r_divisor),
    .o_partial (w_step)
  );

`ifdef DIV_SIGNED_EN
  logic r_neg_quo, w_neg_quo;
  logic r_neg_rem, w_neg_rem;

  assign w_op1_mag = abs32(opdata1_i, signed_div_i);
  assign w_op2_mag = abs32(opdata2_i, signed_div_i);
  // Quotient sign follows the XOR of operand signs; remainder follows the dividend.
  assign w_quo = r_neg_quo ? (~w_step[31:0] + 32'd1) : w_step[31:0];
  assign w_rem = r_neg_rem ? (~w_step[63:32] + 32'd1) : w_step[63:32];
`else
  logic w_unused_sign;
  assign w_unused_sign = signed_div_i;
  assign w_op1_mag = opdata1_i;
  assign w_op2_mag = opdata2_i;
  assign w_quo     = w_step[31:0];
  assign w_rem     = w_step[63:32];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DIV_FREE;
      r_cnt     <= '0;
      r_part    <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_ready   <= DIV_RESULT_NOT_READY;
      r_busy    <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_part    <= w_part;
      r_divisor <= w_divisor;
      r_result  <= w_result;
      r_ready   <= w_ready;
      r_busy    <= w_busy;
`ifdef DIV_SIGNED_EN
      r_neg_quo <= w_neg_quo;
      r_neg_rem <= w_neg_rem;
`endif
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_part    = r_part;
    w_divisor = r_divisor;
    w_result  = r_result;
    w_ready   = r_ready;
    w_busy    = r_busy;
`ifdef DIV_SIGNED_EN
    w_neg_quo = r_neg_quo;
    w_neg_rem = r_neg_rem;
`endif
    case (r_state)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          w_part    = {33'd0, w_op1_mag};
          w_divisor = w_op2_mag;
          w_cnt     = '0;
          w_busy    = 1'b1;
          w_state   = (opdata2_i == 32'd0) ? DIV_BY_ZERO : DIV_ON;
`ifdef DIV_SIGNED_EN
          w_neg_quo = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          w_neg_rem = signed_div_i & opdata1_i[31];
`endif
        end
      end
      DIV_BY_ZERO: begin
        w_busy   = 1'b0;
        w_result = '0;
        if (annul_i) begin
          w_state = DIV_FREE;
          w_ready = DIV_RESULT_NOT_READY;
        end else begin
          w_state = DIV_END;
          w_ready = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          w_state  = DIV_FREE;
          w_busy   = 1'b0;
          w_result = '0;
          w_ready  = DIV_RESULT_NOT_READY;
        end else begin
          w_part = w_step;
          w_cnt  = r_cnt + 5'd1;
          // The final step's result is sign-fixed and captured on the same edge.
          if (r_cnt == DIV_LAST_CNT) begin
            w_state  = DIV_END;
            w_busy   = 1'b0;
            w_result = {w_rem, w_quo};
            w_ready  = DIV_RESULT_READY;
          end
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          w_state  = DIV_FREE;
          w_result = '0;
          w_ready  = DIV_RESULT_NOT_READY;
        end
      end
      default: w_state = DIV_FREE;
    endcase
  end

  assign result_o    = r_result;
  assign ready_o     = r_ready;
  assign busy_o      = r_busy;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .busy_o       (busy),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference arithmetic ----------------
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sg);
    longint q, r;
    if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
    if (sg) begin
      // 64-bit signed arithmetic: no overflow for -2^31 / -1, truncating division.
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
      return {r[31:0], q[31:0]};
    end
`endif
    q = longint'({32'd0, a}) / longint'({32'd0, b});
    r = longint'({32'd0, a}) % longint'({32'd0, b});
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // Mode 0 idle, 1 running (m_left edges to go), 2 holding a result.
  logic [63:0] exp_q[$];
  int          m_mode  = 0;
  int          m_left  = 0;
  logic        m_busy  = 1'b0;
  logic        m_ready = 1'b0;
  logic [63:0] m_res   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode  <= 0;
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_res   <= '0;
      exp_q.delete();
    end else begin
      case (m_mode)
        0: if (start && !annul) begin
          exp_q.push_back(ref_div(op1, op2, signed_div));
          m_left <= (op2 == 32'd0) ? 1 : 32;
          m_mode <= 1;
          m_busy <= 1'b1;
        end
        1: if (annul) begin
          void'(exp_q.pop_front());
          m_mode <= 0;
          m_busy <= 1'b0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_res   <= exp_q.pop_front();
            m_ready <= 1'b1;
            m_busy  <= 1'b0;
            m_mode  <= 2;
          end
        end
        default: if (!start) begin
          m_mode  <= 0;
          m_ready <= 1'b0;
          m_res   <= '0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_result", result, m_res);
      check("cyc_ready", {63'd0, ready}, {63'd0, m_ready});
      check("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
    end
  end

  // ---------------- driver ----------------
  // Starts a request from FREE. annul_at > 0 aborts it at that edge after E0.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input int hold, input int annul_at, output logic [63:0] got);
    int n;
    got = '0;
    op1 = a; op2 = b; signed_div = sg; start = 1'b1; annul = 1'b0;
    @(posedge clk); #1;  // E0
    // Operand changes after acceptance must not matter.
    op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom_range(0, 1));
    if (annul_at > 0) begin
      repeat (annul_at - 1) begin @(posedge clk); #1; end
      annul = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      annul = 1'b0;
    end else begin
      n = 0;
      while (!ready && n < 100) begin @(posedge clk); #1; n++; end
      check("latency", 64'(n), (b == 32'd0) ? 64'd1 : 64'd32);
      got = result;
      repeat (hold) begin @(posedge clk); #1; end
      start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] got;
    logic [31:0] a, b;
    int n, sel;

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_result", result, 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Pin the reference model against hand-computed values.
    check("model_100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    check("model_5_0", ref_div(32'd5, 32'd0, 1'b0), 64'd0);
    check("model_9_3", ref_div(32'd9, 32'd3, 1'b0), 64'h00000000_00000003);

    // DIVU 100/7, held three cycles.
    run_div(32'd100, 32'd7, 1'b0, 3, 0, got);
    check("divu_100_7", got, 64'h00000002_0000000E);
    check("divu_released", {63'd0, ready}, 64'd0);

    // DIV -100/7.
    run_div(32'hFFFFFF9C, 32'd7, 1'b1, 0, 0, got);
`ifdef DIV_SIGNED_EN
    check("div_m100_7", got, 64'hFFFFFFFE_FFFFFFF2);
`else
    check("div_m100_7", got, 64'h00000002_24924916);
`endif

    // DIV 0x80000000 / 0xFFFFFFFF.
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1, 0, got);
`ifdef DIV_SIGNED_EN
    check("div_min_m1", got, 64'h00000000_80000000);
`else
    check("div_min_m1", got, 64'h80000000_00000000);
`endif

    // Divide by zero.
    run_div(32'd5, 32'd0, 1'b0, 2, 0, got);
    check("divu_5_0", got, 64'd0);

    // Annul at E10, then start+annul together in FREE is not accepted.
    run_div(32'd12345, 32'd17, 1'b0, 0, 10, got);
    check("annul_state", {62'd0, dbg_state}, 64'd0);
    start = 1'b1; annul = 1'b1; op2 = 32'd3;
    @(posedge clk); #1;
    check("start_annul_busy", {63'd0, busy}, 64'd0);
    start = 1'b0; annul = 1'b0;
    run_div(32'd9, 32'd3, 1'b0, 0, 0, got);
    check("divu_9_3", got, 64'h00000000_00000003);

    // Reset at E20 with start held high: re-accepted, full latency.
    op1 = 32'd1000; op2 = 32'd10; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #1;  // E0
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;  // E20
    check("midrst_state", {62'd0, dbg_state}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    n = 0;
    while (!ready && n < 100) begin @(posedge clk); #1; n++; end
    check("midrst_latency", 64'(n), 64'd33);
    check("midrst_result", result, 64'h00000000_00000064);
    start = 1'b0;
    @(posedge clk); #1;

    // Randomized divisions.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'd0;
      else if (sel < 4)  b = 32'($urandom_range(1, 15));
      else if (sel < 6)  b = -32'($urandom_range(1, 15));
      else               b = $urandom;
      if ($urandom_range(0, 7) == 0)
        run_div(a, b, 1'($urandom_range(0, 1)), 0,
                (b == 32'd0) ? 1 : $urandom_range(1, 31), got);
      else
        run_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, got);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle divider sequencer for the EX stage of the OpenMIPS pipeline. It executes DIV/DIVU by restoring division, one quotient bit per clock. It holds the EX stage via `busy_o` while running and presents `{remainder, quotient}` in the HI/LO layout for the `whilo_o`/`hi_o`/`lo_o` path. EX drives start/annul; the pipeline controller turns `busy_o` into a stall request.

## Interface
Parameters:
- None. Width is fixed at 32-bit operands and a 64-bit result.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `signed_div_i` in 1: 1 = DIV (signed), 0 = DIVU.
- `opdata1_i` in 32: dividend.
- `opdata2_i` in 32: divisor.
- `start_i` in 1: request. Held high by EX until the result is consumed.
- `annul_i` in 1: abort the in-flight division (flush or exception).
- `result_o` out 64: `{remainder[63:32] -> HI, quotient[31:0] -> LO}`. Reset value 0.
- `ready_o` out 1: `result_o` valid. Reset value 0.
- `busy_o` out 1: division in progress; stall EX. Reset value 0.

## Operation
- FSM states: FREE, BY_ZERO, ON, END. Reset state is FREE. All outputs are registered.
- FREE:
  - If `start_i`=1 and `annul_i`=0: latch operands and sign flags.
  - Divisor == 0 → BY_ZERO. Otherwise → ON, with counter `cnt`=0.
  - In all other cases stay in FREE.
- BY_ZERO: next edge → END with `result_o`=0.
- ON:
  - Each edge performs one step. Shift register `{rem[32:0], quo[31:0]}` shifts left one bit. Then `rem - divisor`: if non-negative, keep the difference and set the quotient LSB to 1; else restore and set the LSB to 0.
  - `cnt` increments each step. After the step with `cnt`=31 → END.
- END:
  - Load `result_o` at END entry; hold it with `ready_o`=1 while `start_i`=1.
  - When `start_i`=0 → FREE, `ready_o`←0, `result_o`←0.
- Annul: `annul_i`=1 in BY_ZERO or ON → FREE next edge; `result_o`=0 and `ready_o`=0. `annul_i` is ignored in END.
- `busy_o` = 1 in BY_ZERO and ON, 0 in FREE and END.
- Signed handling:
  - Operands are converted to magnitudes before stepping.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - -2^31 / -1 yields quotient 0x80000000, remainder 0; no overflow flag.
- Operand changes after acceptance have no effect.
- `rst` overrides all inputs in any state.

## Timing
- Acceptance edge E0; the ON steps occur at E1..E32. END entry is at E32, so `result_o`/`ready_o` are visible in the cycle after E32.
- Divide by zero: BY_ZERO after E0, END at E1.
- `busy_o` rises after E0 and falls at END entry.
- Back-to-back divisions: `start_i` must drop for at least one cycle in END. The earliest new acceptance is the edge after END exits to FREE.
- Same edge `start_i`=1 and `annul_i`=1 in FREE: not accepted.
- Reset asserted mid-ON: FREE at the next edge, all outputs 0.

## Configuration
- `DIV_SIGNED_EN` defined: DIV signed handling as above.
- Undefined: `signed_div_i` is ignored and all divisions are unsigned. The sign-conversion and negation logic is removed.

## Structure
- Shared package `div_pkg`:
  - State encodings: FREE=2'b00, BY_ZERO=2'b01, ON=2'b10, END=2'b11.
  - `DIV_RESULT_READY`=1'b1, `DIV_RESULT_NOT_READY`=1'b0.
  - `DIV_START`=1'b1, `DIV_STOP`=1'b0.
  - Iteration count 32.
- Sub-module `div_step`: combinational single iteration. 65-bit partial state in, next partial state out.

## Test plan
- DIVU 100/7 → after E32: `result_o`=`{0x00000002, 0x0000000E}`, `ready_o`=1; hold `start_i` 3 cycles → stable; drop `start_i` → FREE, `ready_o`=0.
- DIV -100/7 with `DIV_SIGNED_EN` → quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. Without the macro, same stimulus → quotient 0x24924916, remainder 0x00000002.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- DIVU 5/0 → `busy_o` for one cycle, END at E1, `result_o`=0, `ready_o`=1.
- Annul: `annul_i`=1 at E10 → FREE at E11, `ready_o` never asserts; a new 9/3 request then completes → quotient 3, remainder 0.
- `rst` pulse during ON at E20 → FREE at the next edge, all outputs 0; `start_i` held high → re-accepted after `rst` drops, full 32-step latency.
